// File: rtl/rate_meter_pkg.sv
// Shared constants and FSM encoding for the rate meter and its companion tick divider.
// The board clock also sets the measurement window length.
package rate_meter_pkg;

  localparam int CLOCK_HZ = 50_000_000;
  localparam int RATE_W   = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/rate_meter_edge_rise.sv
// Rising-edge detector: registers the input once and flags a 0->1 transition.
// A level held high produces a single one-cycle flag.
module edge_rise (
  input  logic clock,
  input  logic resetn,
  input  logic sig_in,
  output logic rise
);

  logic sig_d_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sig_d_reg <= 1'b0;
    end else begin
      sig_d_reg <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_d_reg;

endmodule

// File: rtl/rate_meter.sv
// Counts rising edges of tick_in over back-to-back windows of CLK_HZ clock cycles
// and reports each completed window as a saturated RATE_W-bit rate.
module rate_meter
  import rate_meter_pkg::*;
#(
  parameter int CLK_HZ = CLOCK_HZ,
  parameter int RATE_W = rate_meter_pkg::RATE_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              tick_in,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid,
  output logic              overflow
);

  localparam int WIN_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CNT_W = RATE_W + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {1'b1, {RATE_W{1'b0}}};

  meter_state_t      state_reg, state_next;
  logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0]  edge_cnt_reg, edge_cnt_next;
  logic [RATE_W-1:0] rate_reg, rate_next;
  logic              valid_reg, valid_next;
  logic              ovf_reg, ovf_next;
  logic              tick_edge;
  logic              terminal;

  edge_rise u_edge_rise (
    .clock  (clock),
    .resetn (resetn),
    .sig_in (tick_in),
    .rise   (tick_edge)
  );

  assign terminal = (state_reg == ST_MEASURE) && (win_cnt_reg == WIN_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      win_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      rate_reg     <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      win_cnt_reg  <= win_cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      rate_reg     <= rate_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    win_cnt_next  = win_cnt_reg;
    edge_cnt_next = edge_cnt_reg;
    rate_next     = rate_reg;
    valid_next    = 1'b0;
    ovf_next      = ovf_reg;

    case (state_reg)
      ST_IDLE: begin
        win_cnt_next  = '0;
        edge_cnt_next = '0;
        if (enable) begin
          state_next = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        if (terminal) begin
          // Report the finished window; an edge landing now opens the next one.
          rate_next     = edge_cnt_reg[RATE_W] ? {RATE_W{1'b1}} : edge_cnt_reg[RATE_W-1:0];
          ovf_next      = (edge_cnt_reg == CNT_SAT);
          valid_next    = 1'b1;
          win_cnt_next  = '0;
          edge_cnt_next = {{(CNT_W-1){1'b0}}, tick_edge};
          if (!enable) begin
            state_next = ST_IDLE;
          end
        end else if (!enable) begin
          state_next    = ST_IDLE;
          win_cnt_next  = '0;
          edge_cnt_next = '0;
        end else begin
          win_cnt_next = win_cnt_reg + 1'b1;
          if (tick_edge && (edge_cnt_reg != CNT_SAT)) begin
            edge_cnt_next = edge_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rate_out   = rate_reg;
  assign rate_valid = valid_reg;
  assign overflow   = ovf_reg;

endmodule

// File: tb/tb_rate_meter.sv
// Directed bench for rate_meter with a 100-cycle window; an 8-bit and a 4-bit
// instance share the same stimulus so saturation can be observed alongside.
module tb_rate_meter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic       tick_in;
  logic [7:0] rate8;
  logic       valid8, ovf8;
  logic [3:0] rate4;
  logic       valid4, ovf4;

  int checks = 0;
  int errors = 0;

  int q8r[$], q8o[$], q8i[$];
  int q4r[$], q4o[$], q4i[$];

  always #5 clock = ~clock;

  rate_meter #(.CLK_HZ(100), .RATE_W(8)) dut8 (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .tick_in    (tick_in),
    .rate_out   (rate8),
    .rate_valid (valid8),
    .overflow   (ovf8)
  );

  rate_meter #(.CLK_HZ(100), .RATE_W(4)) dut4 (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .tick_in    (tick_in),
    .rate_out   (rate4),
    .rate_valid (valid4),
    .overflow   (ovf4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Iteration i drives tick_in, then samples outputs just after the following edge.
  // period>0: one-cycle pulse when i%period==phase; period==0: level hold from i>=phase.
  task automatic run(input int n, input int period, input int phase, input logic hold);
    q8r.delete(); q8o.delete(); q8i.delete();
    q4r.delete(); q4o.delete(); q4i.delete();
    for (int i = 0; i < n; i++) begin
      if (period > 0) tick_in = ((i % period) == phase);
      else            tick_in = (i >= phase) ? hold : 1'b0;
      step();
      if (valid8) begin
        q8r.push_back(int'(rate8)); q8o.push_back(int'(ovf8)); q8i.push_back(i);
        $display("report dut8 iter %0d rate %0d ovf %0d", i, rate8, ovf8);
      end
      if (valid4) begin
        q4r.push_back(int'(rate4)); q4o.push_back(int'(ovf4)); q4i.push_back(i);
        $display("report dut4 iter %0d rate %0d ovf %0d", i, rate4, ovf4);
      end
    end
  endtask

  task automatic restart();
    enable  = 1'b0;
    tick_in = 1'b0;
    repeat (3) step();
    enable = 1'b1;
  endtask

  task automatic chk_rep(input string tag, input bit is4, input int idx,
                         input int er, input int eo, input int ei);
    int r, o, it;
    r = -1; o = -1; it = -1;
    if (is4) begin
      if (idx < q4r.size()) begin r = q4r[idx]; o = q4o[idx]; it = q4i[idx]; end
    end else begin
      if (idx < q8r.size()) begin r = q8r[idx]; o = q8o[idx]; it = q8i[idx]; end
    end
    chk({tag, "_rate"}, r, er);
    chk({tag, "_ovf"}, o, eo);
    chk({tag, "_iter"}, it, ei);
  endtask

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    tick_in = 1'b0;
    #2;
    chk("rst_rate8", int'(rate8), 0);
    chk("rst_valid8", int'(valid8), 0);
    chk("rst_ovf8", int'(ovf8), 0);
    chk("rst_rate4", int'(rate4), 0);
    repeat (3) step();
    resetn = 1'b1;

    // 1: idle for 300 cycles
    run(300, 0, 0, 1'b0);
    chk("idle_reports8", q8r.size(), 0);
    chk("idle_reports4", q4r.size(), 0);
    chk("idle_rate8", int'(rate8), 0);
    chk("idle_ovf8", int'(ovf8), 0);

    // 2: pulse every 10 cycles
    restart();
    run(301, 10, 1, 1'b0);
    chk("p10_count", q8r.size(), 3);
    chk_rep("p10_r0", 1'b0, 0, 10, 0, 100);
    chk_rep("p10_r1", 1'b0, 1, 10, 0, 200);
    chk_rep("p10_r2", 1'b0, 2, 10, 0, 300);

    // 3: level held high counts once
    restart();
    run(250, 0, 1, 1'b1);
    chk("hold_count", q8r.size(), 2);
    chk_rep("hold_r0", 1'b0, 0, 1, 0, 100);
    chk_rep("hold_r1", 1'b0, 1, 0, 0, 200);

    // 4: single edge on the terminal cycle belongs to the next window
    restart();
    run(250, 1000, 100, 1'b0);
    chk("term_count", q8r.size(), 2);
    chk_rep("term_r0", 1'b0, 0, 0, 0, 100);
    chk_rep("term_r1", 1'b0, 1, 1, 0, 200);

    // 5: 50 edges/window saturates the 4-bit meter, then 5 edges/window clears overflow
    restart();
    run(101, 2, 1, 1'b0);
    chk_rep("tog_w4", 1'b1, 0, 15, 1, 100);
    chk_rep("tog_w8", 1'b0, 0, 50, 0, 100);
    restart();
    run(101, 20, 1, 1'b0);
    chk_rep("five_w4", 1'b1, 0, 5, 0, 100);
    chk_rep("five_w8", 1'b0, 0, 5, 0, 100);

    // 6: drop enable at win_cnt=50 after 7 edges; partial window discarded
    restart();
    run(51, 7, 2, 1'b0);
    chk("abort_pre_reports", q8r.size(), 0);
    enable = 1'b0;
    run(20, 0, 0, 1'b0);
    chk("abort_idle_reports", q8r.size() + q4r.size(), 0);
    chk("abort_hold_rate8", int'(rate8), 5);
    chk("abort_hold_rate4", int'(rate4), 5);
    enable = 1'b1;
    run(101, 33, 1, 1'b0);
    chk("reen_count", q8r.size(), 1);
    chk_rep("reen_r0", 1'b0, 0, 3, 0, 100);

    // 6b: reset mid-window clears everything at once
    restart();
    run(51, 7, 2, 1'b0);
    resetn = 1'b0;
    #1;
    chk("mrst_rate8", int'(rate8), 0);
    chk("mrst_rate4", int'(rate4), 0);
    chk("mrst_ovf8", int'(ovf8), 0);
    chk("mrst_valid8", int'(valid8), 0);
    repeat (2) step();
    resetn = 1'b1;
    run(120, 0, 0, 1'b0);
    chk("mrst_after_rate", q8r.size() > 0 ? q8r[0] : -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
